// File: rtl/sim_sram_mp_if.sv
// rtl/sim_sram_mp_if.sv - request/response bus of the multi-port simulation SRAM
interface sim_sram_mp_if #(
  parameter int NumPorts  = 2,
  parameter int AddrWidth = 10,
  parameter int DataWidth = 64,
  parameter int BeWidth   = 8
);
  logic [NumPorts-1:0]           req_i;
  logic [NumPorts-1:0]           gnt_o;
  logic [NumPorts-1:0]           we_i;
  logic [NumPorts*AddrWidth-1:0] addr_i;
  logic [NumPorts*DataWidth-1:0] wdata_i;
  logic [NumPorts*BeWidth-1:0]   be_i;
  logic [NumPorts-1:0]           rvalid_o;
  logic [NumPorts*DataWidth-1:0] rdata_o;
  logic [NumPorts-1:0]           err_o;
  logic                          init_done_o;
  logic [31:0]                   collision_cnt_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, init_done_o, collision_cnt_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rvalid_o, rdata_o, err_o, init_done_o, collision_cnt_o
  );
endinterface

// File: rtl/sim_sram_mp.sv
// rtl/sim_sram_mp.sv - multi-port functional SRAM model with init sweep and collision counting
module sim_sram_mp #(
  parameter int NumWords     = 1024,
  parameter int DataWidth    = 64,
  parameter int ByteWidth    = 8,
  parameter int NumPorts     = 2,
  parameter int Latency      = 1,
  parameter int RdMode       = 0,
  parameter int ClearOnReset = 1,
  parameter logic [DataWidth-1:0] InitValue = '0,
  localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input logic          clk_i,
  input logic          rst_i,
  sim_sram_mp_if.slave bus
);

  localparam logic [AddrWidth-1:0] LP_LAST = AddrWidth'(NumWords - 1);
  localparam logic [AddrWidth:0]   LP_NW   = (AddrWidth+1)'(NumWords);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t               r_state, w_state_nxt;
  logic [AddrWidth-1:0] r_ptr, w_ptr_nxt;
  logic                 w_sweep_we;
  logic                 w_init_done;

  logic [DataWidth-1:0] r_mem [NumWords];

  logic [AddrWidth-1:0] w_addr  [NumPorts];
  logic [DataWidth-1:0] w_wdata [NumPorts];
  logic [BeWidth-1:0]   w_be    [NumPorts];
  logic [DataWidth-1:0] w_bmask [NumPorts];
  logic [DataWidth-1:0] w_rdata [NumPorts];
  logic [NumPorts-1:0]  w_acc, w_oor, w_wr, w_rd;
  logic                 w_coll;

  logic [NumPorts-1:0]  r_vld [Latency];
  logic [NumPorts-1:0]  r_err [Latency];
  logic [DataWidth-1:0] r_dat [Latency][NumPorts];
  logic [31:0]          r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= (ClearOnReset != 0) ? ST_INIT : ST_READY;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sweep_we  = 1'b0;
    w_init_done = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_sweep_we = 1'b1;
        if (r_ptr == LP_LAST) begin
          w_state_nxt = ST_READY;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      ST_READY: begin
        w_init_done = 1'b1;
      end
      default: begin
        w_state_nxt = ST_READY;
      end
    endcase
  end

  assign bus.init_done_o = w_init_done;
  assign bus.gnt_o       = bus.req_i & {NumPorts{w_init_done}};

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      w_addr[p]  = bus.addr_i[p*AddrWidth +: AddrWidth];
      w_wdata[p] = bus.wdata_i[p*DataWidth +: DataWidth];
      w_be[p]    = bus.be_i[p*BeWidth +: BeWidth];
      for (int b = 0; b < DataWidth; b++) begin
        w_bmask[p][b] = w_be[p][b / ByteWidth];
      end
      w_acc[p] = bus.req_i[p] & w_init_done;
      w_oor[p] = ({1'b0, w_addr[p]} >= LP_NW);
      w_wr[p]  = w_acc[p] & bus.we_i[p] & ~w_oor[p];
      w_rd[p]  = w_acc[p] & ~bus.we_i[p];
    end
  end

  // Write-first view: overlay this edge's writes in port order so the highest port wins per byte.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      w_rdata[p] = w_oor[p] ? '0 : r_mem[w_addr[p]];
      if (RdMode != 0) begin
        for (int q = 0; q < NumPorts; q++) begin
          if (w_wr[q] && !w_oor[p] && (w_addr[q] == w_addr[p])) begin
            for (int b = 0; b < DataWidth; b++) begin
              if (w_bmask[q][b]) w_rdata[p][b] = w_wdata[q][b];
            end
          end
        end
      end
    end
  end

  always_comb begin
    w_coll = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      for (int q = p + 1; q < NumPorts; q++) begin
        if (w_wr[p] && w_wr[q] && (w_addr[p] == w_addr[q]) && (|(w_be[p] & w_be[q]))) begin
          w_coll = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_sweep_we) r_mem[r_ptr] <= InitValue;
    for (int p = 0; p < NumPorts; p++) begin
      if (w_wr[p]) begin
        for (int b = 0; b < DataWidth; b++) begin
          if (w_bmask[p][b]) r_mem[w_addr[p]][b] <= w_wdata[p][b];
        end
      end
    end
  end

  // Data stages only advance with a valid so the output holds the last response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < Latency; k++) begin
        r_vld[k] <= '0;
        r_err[k] <= '0;
        for (int p = 0; p < NumPorts; p++) r_dat[k][p] <= '0;
      end
    end else begin
      r_vld[0] <= w_rd;
      r_err[0] <= w_acc & w_oor;
      for (int p = 0; p < NumPorts; p++) begin
        if (w_rd[p]) r_dat[0][p] <= w_rdata[p];
      end
      for (int k = 1; k < Latency; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_err[k] <= r_err[k-1];
        for (int p = 0; p < NumPorts; p++) begin
          if (r_vld[k-1][p]) r_dat[k][p] <= r_dat[k-1][p];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_coll && (r_cnt != 32'hFFFF_FFFF)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign bus.rvalid_o        = r_vld[Latency-1];
  assign bus.err_o           = r_err[Latency-1];
  assign bus.collision_cnt_o = r_cnt;

  always_comb begin
    bus.rdata_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      bus.rdata_o[p*DataWidth +: DataWidth] = r_dat[Latency-1][p];
    end
  end

endmodule

// File: tb/tb_sim_sram_mp.sv
// tb/tb_sim_sram_mp.sv - two-configuration bench for sim_sram_mp against an array/queue reference model
module tb_sim_sram_mp;

  localparam logic [63:0] INIT = 64'hA5A5_A5A5_A5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sim_sram_mp_if #(.NumPorts(2), .AddrWidth(4), .DataWidth(64), .BeWidth(8)) if_a ();
  sim_sram_mp_if #(.NumPorts(2), .AddrWidth(4), .DataWidth(64), .BeWidth(8)) if_b ();

  assign if_b.req_i   = if_a.req_i;
  assign if_b.we_i    = if_a.we_i;
  assign if_b.addr_i  = if_a.addr_i;
  assign if_b.wdata_i = if_a.wdata_i;
  assign if_b.be_i    = if_a.be_i;

  sim_sram_mp #(.NumWords(12), .DataWidth(64), .ByteWidth(8), .NumPorts(2), .Latency(2),
                .RdMode(0), .ClearOnReset(1), .InitValue(INIT))
    u_a (.clk_i(clk), .rst_i(rst), .bus(if_a));

  sim_sram_mp #(.NumWords(16), .DataWidth(64), .ByteWidth(8), .NumPorts(2), .Latency(1),
                .RdMode(1), .ClearOnReset(1), .InitValue(INIT))
    u_b (.clk_i(clk), .rst_i(rst), .bus(if_b));

  logic [1:0]   o_gnt [2];
  logic [1:0]   o_rv  [2];
  logic [1:0]   o_err [2];
  logic [127:0] o_rd  [2];
  logic         o_done[2];
  logic [31:0]  o_cnt [2];

  assign o_gnt[0] = if_a.gnt_o;    assign o_gnt[1] = if_b.gnt_o;
  assign o_rv[0]  = if_a.rvalid_o; assign o_rv[1]  = if_b.rvalid_o;
  assign o_err[0] = if_a.err_o;    assign o_err[1] = if_b.err_o;
  assign o_rd[0]  = if_a.rdata_o;  assign o_rd[1]  = if_b.rdata_o;
  assign o_done[0] = if_a.init_done_o; assign o_done[1] = if_b.init_done_o;
  assign o_cnt[0] = if_a.collision_cnt_o; assign o_cnt[1] = if_b.collision_cnt_o;

  // Reference model: config d=0 is 12 words/latency 2/read-first, d=1 is 16 words/latency 1/write-first.
  int          nw   [2] = '{12, 16};
  int          lat  [2] = '{2, 1};
  int          mode [2] = '{0, 1};
  logic [63:0] mem  [2][16];
  int          edges[2];
  longint      cnt  [2];
  bit          rv   [2][2][16];
  bit          re   [2][2][16];
  logic [63:0] rdq  [2][2][16];
  logic [63:0] last [2][2];
  int          cyc;
  int          nvec;
  int          nerr;

  task automatic chk(input string tag, input int d, input int p, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s cfg%0d port%0d cyc%0d: observed %h expected %h", tag, d, p, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      edges[d] = 0;
      cnt[d]   = 0;
      for (int w = 0; w < 16; w++) mem[d][w] = INIT;
      for (int p = 0; p < 2; p++) begin
        last[d][p] = '0;
        for (int s = 0; s < 16; s++) begin
          rv[d][p][s] = 1'b0;
          re[d][p][s] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    int s;
    s = cyc % 16;
    for (int d = 0; d < 2; d++) begin
      chk("init_done", d, 0, 64'(o_done[d]), 64'(edges[d] >= nw[d]));
      chk("collision_cnt", d, 0, 64'(o_cnt[d]), 64'(cnt[d]));
      for (int p = 0; p < 2; p++) begin
        if (rv[d][p][s]) last[d][p] = rdq[d][p][s];
        chk("rvalid", d, p, 64'(o_rv[d][p]), 64'(rv[d][p][s]));
        chk("err", d, p, 64'(o_err[d][p]), 64'(re[d][p][s]));
        chk("rdata", d, p, o_rd[d][p*64 +: 64], last[d][p]);
        rv[d][p][s] = 1'b0;
        re[d][p][s] = 1'b0;
      end
    end
  endtask

  task automatic step(input logic [1:0] req, input logic [1:0] we,
                      input logic [3:0] ad0, input logic [3:0] ad1,
                      input logic [63:0] wd0, input logic [63:0] wd1,
                      input logic [7:0] be0, input logic [7:0] be1);
    logic [3:0]  ad [2];
    logic [63:0] wd [2];
    logic [7:0]  be [2];
    logic [63:0] nm [16];
    bit          rdy;
    int          slot;
    ad[0] = ad0; ad[1] = ad1;
    wd[0] = wd0; wd[1] = wd1;
    be[0] = be0; be[1] = be1;
    if_a.req_i   = req;
    if_a.we_i    = we;
    if_a.addr_i  = {ad1, ad0};
    if_a.wdata_i = {wd1, wd0};
    if_a.be_i    = {be1, be0};
    #1;
    for (int d = 0; d < 2; d++) begin
      rdy = (edges[d] >= nw[d]);
      chk("gnt", d, 0, 64'(o_gnt[d]), 64'(req & {2{rdy}}));
      if (rdy) begin
        for (int w = 0; w < 16; w++) nm[w] = mem[d][w];
        for (int p = 0; p < 2; p++) begin
          if (req[p] && we[p] && (int'(ad[p]) < nw[d])) begin
            for (int j = 0; j < 8; j++) begin
              if (be[p][j]) nm[ad[p]][8*j +: 8] = wd[p][8*j +: 8];
            end
          end
        end
        if ((req == 2'b11) && (we == 2'b11) && (ad0 == ad1) && (int'(ad0) < nw[d]) &&
            ((be0 & be1) != 8'h00) && (cnt[d] < 64'hFFFF_FFFF)) begin
          cnt[d]++;
        end
        slot = (cyc + lat[d]) % 16;
        for (int p = 0; p < 2; p++) begin
          if (req[p]) begin
            if (int'(ad[p]) >= nw[d]) begin
              re[d][p][slot] = 1'b1;
              rv[d][p][slot] = !we[p];
              rdq[d][p][slot] = '0;
            end else if (!we[p]) begin
              rv[d][p][slot] = 1'b1;
              rdq[d][p][slot] = (mode[d] != 0) ? nm[ad[p]] : mem[d][ad[p]];
            end
          end
        end
        for (int w = 0; w < 16; w++) mem[d][w] = nm[w];
      end
      edges[d]++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 4'd0, 4'd0, '0, '0, 8'h00, 8'h00);
  endtask

  task automatic rd(input logic [1:0] req, input logic [3:0] ad0, input logic [3:0] ad1);
    step(req, 2'b00, ad0, ad1, '0, '0, 8'h00, 8'h00);
  endtask

  // Asynchronous reset lands between edges; outputs must clear without waiting for a clock.
  task automatic pulse_reset();
    if_a.req_i = 2'b11;
    if_a.we_i  = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt", d, 0, 64'(o_gnt[d]), 64'd0);
      chk("rst_rvalid", d, 0, 64'(o_rv[d]), 64'd0);
      chk("rst_err", d, 0, 64'(o_err[d]), 64'd0);
      chk("rst_rdata", d, 0, o_rd[d][63:0] | o_rd[d][127:64], 64'd0);
      chk("rst_done", d, 0, 64'(o_done[d]), 64'd0);
      chk("rst_cnt", d, 0, 64'(o_cnt[d]), 64'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [3:0] a0, a1;
    nvec = 0;
    nerr = 0;
    cyc  = 0;
    if_a.req_i = '0; if_a.we_i = '0; if_a.addr_i = '0; if_a.wdata_i = '0; if_a.be_i = '0;
    model_reset();
    @(negedge clk);
    pulse_reset();

    for (int i = 0; i < 17; i++) rd(2'b11, 4'd15, 4'd3);
    idle(2);

    step(2'b01, 2'b01, 4'd3, 4'd0, 64'hDEAD_BEEF, '0, 8'hFF, 8'h00);
    rd(2'b01, 4'd3, 4'd0);
    idle(3);

    step(2'b11, 2'b11, 4'd7, 4'd7, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 8'hFF, 8'h0F);
    rd(2'b11, 4'd7, 4'd7);
    idle(2);

    step(2'b01, 2'b01, 4'd5, 4'd0, 64'hAA, '0, 8'hFF, 8'h00);
    step(2'b11, 2'b01, 4'd5, 4'd5, 64'h55, '0, 8'hFF, 8'h00);
    idle(3);

    rd(2'b01, 4'd13, 4'd0);
    step(2'b11, 2'b10, 4'd2, 4'd14, '0, 64'h0BAD_0BAD_0BAD_0BAD, 8'h00, 8'hFF);
    rd(2'b01, 4'd2, 4'd0);
    rd(2'b11, 4'd11, 4'd12);
    idle(3);

    for (int i = 0; i < 300; i++) begin
      a0 = ($urandom % 2 != 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(10, 13));
      a1 = ($urandom % 2 != 0) ? 4'($urandom_range(0, 15)) : a0;
      step(2'($urandom), 2'($urandom), a0, a1, {$urandom, $urandom}, {$urandom, $urandom},
           8'($urandom), 8'($urandom));
    end
    idle(3);

    rd(2'b11, 4'd3, 4'd9);
    pulse_reset();
    for (int i = 0; i < 17; i++) rd(2'b11, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    for (int w = 0; w < 16; w += 2) rd(2'b11, 4'(w), 4'(w + 1));
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    nerr++;
    $display("FAIL timeout: bench did not reach its summary, observed cyc %0d expected < 2000", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1);
  end

endmodule
